// File: rtl/audio_buf_pkg.sv
// Shared types and helpers for the audio sample buffer: FSM states,
// default sample width, priming threshold and saturating increment.
package audio_buf_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } buf_state_e;

    // Level the FIFO must reach before samples are released downstream.
    function automatic int prime_thresh(input int depth);
        return depth / 2;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/sample_fifo_core.sv
// Storage array, wrapping pointers and explicit level for the sample FIFO.
// A write while full is only taken when a read frees a slot in the same cycle.
module sample_fifo_core #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     AUDIO_MCLK,
    input  logic                     RESET_n,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign wr_ok   = wr & (~full | rd);
    assign rd_ok   = rd & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the array has no reset; the level alone decides which entries are live.
    always_ff @(posedge AUDIO_MCLK) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge AUDIO_MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_buffer.sv
// Elastic buffer between the I2S frame strobe and the FM modulator's
// valid/ready pull, with priming FSM and saturating over/underflow counters.
module audio_sample_buffer
    import audio_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     AUDIO_MCLK,
    input  logic                     RESET_n,
    input  logic                     SAMPLE_TR,
    input  logic [DATA_W-1:0]        SUM_AUDIO,
    input  logic                     ENABLE,
    input  logic                     CLR_STATS,
    input  logic                     OUT_READY,
    output logic                     OUT_VALID,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic [$clog2(DEPTH):0]   FILL_LEVEL,
    output logic [CNT_W-1:0]         OVERFLOW_CNT,
    output logic [CNT_W-1:0]         UNDERFLOW_CNT
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] THRESH = LW'(prime_thresh(DEPTH));

    buf_state_e        state;
    buf_state_e        state_nxt;
    logic              st_d1;
    logic              st_d2;
    logic              wr_req;
    logic              active;
    logic              pop;
    logic              flush;
    logic              overflow_ev;
    logic              underflow_ev;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] hold;

    // Rising-edge detect: a strobe held high for several cycles writes once.
    assign wr_req       = st_d1 & ~st_d2;
    assign active       = ENABLE & (state != IDLE);
    assign flush        = ~ENABLE | (state == IDLE);
    assign OUT_VALID    = (state == RUN) & ~empty;
    assign pop          = OUT_VALID & OUT_READY;
    assign overflow_ev  = wr_req & active & full & ~pop;
    assign underflow_ev = (state == RUN) & empty & OUT_READY;
    assign OUT_DATA     = OUT_VALID ? head : hold;

    sample_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .AUDIO_MCLK (AUDIO_MCLK),
        .RESET_n    (RESET_n),
        .flush      (flush),
        .wr         (wr_req & active),
        .wr_data    (SUM_AUDIO),
        .rd         (pop),
        .rd_data    (head),
        .level      (FILL_LEVEL),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge AUDIO_MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            st_d1 <= 1'b0;
            st_d2 <= 1'b0;
            state <= IDLE;
            hold  <= '0;
        end else begin
            st_d1 <= SAMPLE_TR;
            st_d2 <= st_d1;
            state <= state_nxt;
            if (pop) hold <= head;
        end
    end

    // NOTE: next state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        if (!ENABLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   if (FILL_LEVEL >= THRESH) state_nxt = RUN;
                RUN:     if (underflow_ev) state_nxt = PRIME;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Statistics survive ENABLE toggling; a clear beats a coincident event.
    always_ff @(posedge AUDIO_MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            OVERFLOW_CNT  <= '0;
            UNDERFLOW_CNT <= '0;
        end else if (CLR_STATS) begin
            OVERFLOW_CNT  <= '0;
            UNDERFLOW_CNT <= '0;
        end else begin
            if (overflow_ev)  OVERFLOW_CNT  <= CNT_W'(sat_inc(32'(OVERFLOW_CNT), CNT_W));
            if (underflow_ev) UNDERFLOW_CNT <= CNT_W'(sat_inc(32'(UNDERFLOW_CNT), CNT_W));
        end
    end

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Scoreboard bench for audio_sample_buffer: stimulus queues expected samples,
// a negedge monitor compares every accepted output beat against the queue.
module tb_audio_sample_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;

    logic                   AUDIO_MCLK;
    logic                   RESET_n;
    logic                   SAMPLE_TR;
    logic [DATA_W-1:0]      SUM_AUDIO;
    logic                   ENABLE;
    logic                   CLR_STATS;
    logic                   OUT_READY;
    logic                   OUT_VALID;
    logic [DATA_W-1:0]      OUT_DATA;
    logic [$clog2(DEPTH):0] FILL_LEVEL;
    logic [CNT_W-1:0]       OVERFLOW_CNT;
    logic [CNT_W-1:0]       UNDERFLOW_CNT;

    int n_pass  = 0;
    int n_total = 0;
    logic [DATA_W-1:0] exp_q[$];

    audio_sample_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .AUDIO_MCLK    (AUDIO_MCLK),
        .RESET_n       (RESET_n),
        .SAMPLE_TR     (SAMPLE_TR),
        .SUM_AUDIO     (SUM_AUDIO),
        .ENABLE        (ENABLE),
        .CLR_STATS     (CLR_STATS),
        .OUT_READY     (OUT_READY),
        .OUT_VALID     (OUT_VALID),
        .OUT_DATA      (OUT_DATA),
        .FILL_LEVEL    (FILL_LEVEL),
        .OVERFLOW_CNT  (OVERFLOW_CNT),
        .UNDERFLOW_CNT (UNDERFLOW_CNT)
    );

    initial AUDIO_MCLK = 1'b0;
    always #5 AUDIO_MCLK = ~AUDIO_MCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge AUDIO_MCLK);
        #1;
    endtask

    // One frame strobe held for hold_cyc cycles; ends with the write visible in FILL_LEVEL.
    task automatic strobe(input logic [DATA_W-1:0] value, input int hold_cyc, input bit expect_out);
        SAMPLE_TR = 1'b1;
        SUM_AUDIO = value;
        if (expect_out) exp_q.push_back(value);
        repeat (hold_cyc) tick();
        SAMPLE_TR = 1'b0;
        tick();
        tick();
    endtask

    always @(negedge AUDIO_MCLK) begin
        if (RESET_n && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) check("pop_has_expected", 32'(exp_q.size()), 32'd1);
            else check("pop_data", 32'(OUT_DATA), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_n   = 1'b0;
        SAMPLE_TR = 1'b0;
        SUM_AUDIO = '0;
        ENABLE    = 1'b0;
        CLR_STATS = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) tick();
        RESET_n = 1'b1;
        tick();

        check("reset_valid", 32'(OUT_VALID), 32'd0);
        check("reset_data", 32'(OUT_DATA), 32'd0);
        check("reset_level", 32'(FILL_LEVEL), 32'd0);
        check("reset_ovf", 32'(OVERFLOW_CNT), 32'd0);
        check("reset_unf", 32'(UNDERFLOW_CNT), 32'd0);

        // Priming: three writes stay hidden, the fourth releases RUN two cycles after wr_req.
        ENABLE = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) strobe(DATA_W'(16'h1000 * i), 1, 1'b1);
        check("prime3_level", 32'(FILL_LEVEL), 32'd3);
        check("prime3_valid", 32'(OUT_VALID), 32'd0);
        SAMPLE_TR = 1'b1;
        SUM_AUDIO = 16'h4000;
        exp_q.push_back(16'h4000);
        tick();
        SAMPLE_TR = 1'b0;
        tick();
        check("prime4_level", 32'(FILL_LEVEL), 32'd4);
        check("prime4_valid_not_early", 32'(OUT_VALID), 32'd0);
        tick();
        check("run_valid", 32'(OUT_VALID), 32'd1);
        check("run_head", 32'(OUT_DATA), 32'h1000);

        OUT_READY = 1'b1;
        repeat (4) tick();
        OUT_READY = 1'b0;
        check("drain_level", 32'(FILL_LEVEL), 32'd0);
        check("drain_valid", 32'(OUT_VALID), 32'd0);
        check("drain_hold", 32'(OUT_DATA), 32'h4000);
        check("drain_unf", 32'(UNDERFLOW_CNT), 32'd0);

        // Starvation: RUN, empty, ready high.
        OUT_READY = 1'b1;
        tick();
        check("unf_cnt", 32'(UNDERFLOW_CNT), 32'd1);
        check("unf_valid", 32'(OUT_VALID), 32'd0);
        check("unf_hold", 32'(OUT_DATA), 32'h4000);
        tick();
        tick();
        check("unf_once_in_prime", 32'(UNDERFLOW_CNT), 32'd1);
        OUT_READY = 1'b0;

        // Ten writes into eight slots.
        for (int i = 1; i <= 10; i++) strobe(DATA_W'(i), 1, i <= 8);
        check("ovf_level", 32'(FILL_LEVEL), 32'd8);
        check("ovf_cnt", 32'(OVERFLOW_CNT), 32'd2);
        check("ovf_valid", 32'(OUT_VALID), 32'd1);
        check("ovf_head", 32'(OUT_DATA), 32'd1);

        // Full with write and pop in the same cycle.
        SAMPLE_TR = 1'b1;
        SUM_AUDIO = 16'h00BB;
        exp_q.push_back(16'h00BB);
        tick();
        SAMPLE_TR = 1'b0;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        tick();
        check("fullpop_level", 32'(FILL_LEVEL), 32'd8);
        check("fullpop_ovf", 32'(OVERFLOW_CNT), 32'd2);
        check("fullpop_head", 32'(OUT_DATA), 32'd2);

        // Long strobe yields a single write.
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("pop1_level", 32'(FILL_LEVEL), 32'd7);
        strobe(16'h00CC, 5, 1'b1);
        check("long_strobe_level", 32'(FILL_LEVEL), 32'd8);
        check("long_strobe_ovf", 32'(OVERFLOW_CNT), 32'd2);

        OUT_READY = 1'b1;
        repeat (8) tick();
        OUT_READY = 1'b0;
        check("drain2_level", 32'(FILL_LEVEL), 32'd0);
        check("drain2_hold", 32'(OUT_DATA), 32'h00CC);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // ENABLE dropped with data in flight.
        strobe(16'h00DD, 1, 1'b0);
        strobe(16'h00EE, 1, 1'b0);
        check("pre_disable_level", 32'(FILL_LEVEL), 32'd2);
        check("pre_disable_valid", 32'(OUT_VALID), 32'd1);
        ENABLE = 1'b0;
        tick();
        check("disable_level", 32'(FILL_LEVEL), 32'd0);
        check("disable_valid", 32'(OUT_VALID), 32'd0);
        check("disable_hold", 32'(OUT_DATA), 32'h00CC);
        check("disable_ovf_kept", 32'(OVERFLOW_CNT), 32'd2);
        check("disable_unf_kept", 32'(UNDERFLOW_CNT), 32'd1);
        strobe(16'h0077, 1, 1'b0);
        check("idle_ignores_write", 32'(FILL_LEVEL), 32'd0);
        check("idle_no_ovf", 32'(OVERFLOW_CNT), 32'd2);

        // Saturation of the overflow counter.
        ENABLE = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) strobe(DATA_W'(16'h0100 + i), 1, 1'b0);
        check("refill_level", 32'(FILL_LEVEL), 32'd8);
        for (int i = 0; i < 300; i++) begin
            SAMPLE_TR = 1'b1;
            tick();
            SAMPLE_TR = 1'b0;
            tick();
        end
        tick();
        tick();
        check("ovf_saturated", 32'(OVERFLOW_CNT), 32'd255);

        // Clear coincident with an overflow event.
        SAMPLE_TR = 1'b1;
        tick();
        SAMPLE_TR = 1'b0;
        CLR_STATS = 1'b1;
        tick();
        CLR_STATS = 1'b0;
        check("clr_ovf", 32'(OVERFLOW_CNT), 32'd0);
        check("clr_unf", 32'(UNDERFLOW_CNT), 32'd0);
        strobe(16'h0055, 1, 1'b0);
        check("ovf_after_clr", 32'(OVERFLOW_CNT), 32'd1);

        // Asynchronous reset mid-operation.
        RESET_n = 1'b0;
        #2;
        check("async_rst_level", 32'(FILL_LEVEL), 32'd0);
        check("async_rst_valid", 32'(OUT_VALID), 32'd0);
        check("async_rst_data", 32'(OUT_DATA), 32'd0);
        check("async_rst_ovf", 32'(OVERFLOW_CNT), 32'd0);
        tick();
        RESET_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_sample_buffer.md
# audio_sample_buffer

Elastic sample buffer directly downstream of the I2S line-in/mic stage, in the AUDIO_MCLK domain. It captures the 16-bit summed audio word once per I2S frame, signalled by the frame strobe SAMPLE_TR, and stores it in a small FIFO. It presents the samples to the FM modulator over a valid/ready handshake. A priming state machine absorbs jitter between the codec frame rate and the modulator's sample pull; overflow and underflow are counted.

## Interface
Parameters:
- DATA_W, 16: sample width (two's complement).
- DEPTH, 8: FIFO entries; power of two, ≥ 4.
- CNT_W, 8: width of the saturating event counters.

Ports:
- AUDIO_MCLK  in  1: clock.
- RESET_n  in  1: reset, asynchronous, active-low.
- SAMPLE_TR  in  1: frame strobe from the I2S stage; nominally 1 cycle wide.
- SUM_AUDIO  in  DATA_W: summed audio word; new value valid from the cycle after SAMPLE_TR.
- ENABLE  in  1: level; low = flush and idle.
- CLR_STATS  in  1: synchronous clear of both counters.
- OUT_READY  in  1: modulator accepts a sample.
- OUT_VALID  out  1: OUT_DATA holds a FIFO sample.
- OUT_DATA  out  DATA_W: head sample when valid, otherwise last popped sample.
- FILL_LEVEL  out  log2(DEPTH)+1: registered occupancy, 0..DEPTH.
- OVERFLOW_CNT  out  CNT_W: dropped writes, saturating.
- UNDERFLOW_CNT  out  CNT_W: starvation events, saturating.

## Operation
- Strobe handling:
  - SAMPLE_TR is registered into st_d1 and st_d2.
  - Write request wr_req = st_d1 & ~st_d2, so a strobe held high for several cycles yields exactly one write.
  - SUM_AUDIO is sampled in the wr_req cycle.
- Pop: pop = OUT_VALID & OUT_READY. The read pointer advances and the popped word is copied into the hold register.
- OUT_DATA:
  - Equals mem[rd_ptr] while OUT_VALID = 1.
  - Equals the hold register otherwise (hold-last-sample; the modulator never sees garbage).
- State machine, states IDLE, PRIME, RUN:
  - IDLE: pointers and level forced to 0; wr_req ignored; OUT_VALID = 0. When ENABLE = 1, go to PRIME next cycle.
  - PRIME: writes accepted, OUT_VALID = 0. When the post-update level reaches ≥ DEPTH/2, go to RUN.
  - RUN: OUT_VALID = (level ≠ 0).
    - If OUT_READY = 1 while level = 0: UNDERFLOW_CNT += 1, go to PRIME.
  - From any state, ENABLE = 0 goes to IDLE next cycle; the FIFO is flushed and the hold register is retained.
- Overflow:
  - wr_req with level = DEPTH and no pop in the same cycle: the incoming sample is dropped and OVERFLOW_CNT += 1.
  - wr_req and pop in the same cycle while full: the write is accepted and the level stays at DEPTH.
- Simultaneous wr_req and pop at any level: both are performed and the level is unchanged.
- Counters:
  - Saturate at 2^CNT_W − 1.
  - CLR_STATS wins over a coincident increment.
  - Counters are retained across ENABLE toggling.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The level is tracked separately, so full and empty are unambiguous.

## Timing
- Reset values: state IDLE, OUT_VALID 0, OUT_DATA 0, hold register 0, FILL_LEVEL 0, both counters 0, st_d1/st_d2 0.
- SAMPLE_TR high in cycle t → wr_req in t+1 → FILL_LEVEL updated in t+2.
- In PRIME, the write that brings the level to DEPTH/2 makes OUT_VALID rise two cycles after that write's wr_req cycle (wr_req in t+1, state RUN and OUT_VALID = 1 from t+3).
- A pop at edge e removes the head. The next entry appears on OUT_DATA in the cycle after e, with zero bubble.
- Underflow is detected in the cycle where state = RUN, level = 0 and OUT_READY = 1. The counter and the state change are visible in the following cycle.
- Reset asserted mid-operation clears everything asynchronously; after release the block restarts in IDLE.

## Structure
- Package audio_buf_pkg holds:
  - the state typedef (IDLE, PRIME, RUN);
  - the DATA_W default;
  - the PRIME_THRESH = DEPTH/2 helper;
  - the saturating-increment function.
- One sub-module, sample_fifo_core, holds the storage array, pointers and level. It takes wr/rd inputs and provides full/empty/level outputs. The top level contains the strobe detect, FSM, hold register and counters.

## Test plan
- Reset, ENABLE = 1, 4 SAMPLE_TR pulses with SUM_AUDIO = 0x1000, 0x2000, 0x3000, 0x4000 → OUT_VALID rises after the 4th (DEPTH = 8); pops return the values in order; FILL_LEVEL returns to 0.
- 10 strobes with no pops → FILL_LEVEL = 8, OVERFLOW_CNT = 2; the FIFO holds samples 1–8.
- In RUN, drain to empty and hold OUT_READY = 1 → UNDERFLOW_CNT = 1, state PRIME, OUT_VALID = 0, OUT_DATA holds the last popped value.
- SAMPLE_TR held high 5 cycles → exactly one write (FILL_LEVEL +1).
- Full FIFO, strobe and pop in the same cycle → level stays 8, OVERFLOW_CNT unchanged; the new sample appears last.
- ENABLE dropped mid-stream → next cycle IDLE, FILL_LEVEL = 0, counters kept. 300 overflows → OVERFLOW_CNT = 255. Then CLR_STATS → 0.
